mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Main control unit for the multicycle MIPS datapath, i.e. the producer side of the OpALU interface consumed by the ALU-control/ALU pair.
- Decodes the instruction opcode across fetch/decode/execute/memory/writeback steps.
- Drives every datapath enable and mux select, including the 2-bit OpALU.
- Handshakes with instruction/data memory through mem_ready, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- ENABLE_ADDI, 1, when 0 opcode 001000 is treated as illegal.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction bits [31:26] from the instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load gated externally by ALU zero
- IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data select (1 = MDR)
- RegDst  out  1  destination select (1 = rd, 0 = rt)
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- OpALU  out  2  00 = add, 01 = subtract, 10 = use funct, 11 = never driven
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  sticky trap flag
- state  out  4  current state encoding, for debug
- instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- State register resets to FETCH. While reset is high, every output is 0 and instr_retired is cleared. Reset mid-instruction abandons it and has no side effects.
- Outputs are decoded from state. The only Mealy terms are the mem_ready-gated ones listed below. Any output not listed for a state is 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, OpALU=00, PCSource=00; IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, OpALU=00. Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R -> EXECUTE
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDI_EXEC (if ENABLE_ADDI=1)
  - anything else -> TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, OpALU=00. Goes to MEM_READ for lw, MEM_WRITE for sw. opcode is sampled again here; the IR is stable.
- MEM_READ: MemRead=1, IorD=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Waits for mem_ready, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, OpALU=10, then R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01, then FETCH.
- JUMP: PCWrite=1, PCSource=10, then FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, OpALU=00, then ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, then FETCH.
- TRAP: all control outputs 0, illegal_op=1. Stays in TRAP until reset; instr_retired is frozen.
- instr_retired increments by 1 on each transition into FETCH from a completion state (MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB). It wraps from 2^CNT_W-1 to 0 with no flag.
- Cycles per instruction with mem_ready tied high:
  - lw 5
  - sw, R, addi 4
  - beq, j 3
- Each wait cycle with mem_ready=0 adds one cycle.
- MemRead and MemWrite are never both high.
- An unused state encoding goes to FETCH on the next edge.

Decomposition:
- mips_pkg holds:
  - opcode constants
  - the state enum (4-bit encodings)
  - OpALU codes (shared with the ALU control unit)
  - ALUSrcB and PCSource codes
- Optional sub-module mips_control_outputs: a purely combinational state+mem_ready -> control vector decoder. The FSM and counter stay in the top module.

Test Plan:
- reset held 3 cycles, then released, mem_ready=1 -> all outputs 0 during reset; first cycle after release shows state=FETCH, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- opcode=100011, mem_ready=1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; MEM_WB has RegWrite=1, MemtoReg=1; instr_retired 0->1.
- opcode=000000 with mem_ready=0 for 3 cycles in FETCH -> stays in FETCH with IRWrite=0 for 3 cycles, then EXECUTE drives OpALU=10 and R_WB drives RegDst=1; total 7 cycles.
- opcode=000100, then 000010 -> BRANCH drives OpALU=01, PCWriteCond=1, PCSource=01; JUMP drives PCWrite=1, PCSource=10; each takes 3 cycles.
- opcode=111111 -> TRAP after DECODE, illegal_op=1 held for 20 cycles with all other outputs 0; reset clears it and returns to FETCH.
- CNT_W=4 with 17 R-type instructions -> instr_retired wraps 15->0 and reads 1; an sw with mem_ready=0 in MEM_WRITE holds MemWrite=1 until ready.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package mips_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11,
      S_TRAP      = 4'd12
   } state_t;

   // OpALU codes consumed by the ALU control unit; 2'b11 is reserved.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] op_alu;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/mips_control_outputs.sv
// Combinational decode of the current FSM state (plus mem_ready for the
// fetch-side Mealy terms) into the full datapath control vector.
module mips_control_outputs
   import mips_pkg::*;
(
   input  logic [3:0] state,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.op_alu    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.op_alu    = ALUOP_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.op_alu        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
         S_TRAP: begin
            ctrl.illegal_op = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: sequencing FSM, retired-instruction counter,
// and reset gating of every control output.
module mips_multicycle_control
   import mips_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int ENABLE_ADDI = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       OpALU,
   output logic [1:0]       PCSource,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_retired
);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;
   ctrl_t            ctrl;

   mips_control_outputs u_outputs (
      .state     (state_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   // retire marks the edge that returns a finished instruction to FETCH.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_R:         state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = (ENABLE_ADDI != 0) ? S_ADDI_EXEC : S_TRAP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            if (opcode == OP_LW)      state_d = S_MEM_READ;
            else if (opcode == OP_SW) state_d = S_MEM_WRITE;
            else                      state_d = S_TRAP;
         end
         S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXECUTE:   state_d = S_R_WB;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      retired_d = retired_q;
      if (retire) retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Outputs are forced low for as long as reset is held, not just after its edge.
   always_comb begin
      PCWrite       = ctrl.pc_write;
      PCWriteCond   = ctrl.pc_write_cond;
      IorD          = ctrl.iord;
      MemRead       = ctrl.mem_read;
      MemWrite      = ctrl.mem_write;
      IRWrite       = ctrl.ir_write;
      MemtoReg      = ctrl.mem_to_reg;
      RegDst        = ctrl.reg_dst;
      RegWrite      = ctrl.reg_write;
      ALUSrcA       = ctrl.alu_src_a;
      ALUSrcB       = ctrl.alu_src_b;
      OpALU         = ctrl.op_alu;
      PCSource      = ctrl.pc_source;
      illegal_op    = ctrl.illegal_op;
      state         = state_q;
      instr_retired = retired_q;
      if (reset) begin
         PCWrite       = 1'b0;
         PCWriteCond   = 1'b0;
         IorD          = 1'b0;
         MemRead       = 1'b0;
         MemWrite      = 1'b0;
         IRWrite       = 1'b0;
         MemtoReg      = 1'b0;
         RegDst        = 1'b0;
         RegWrite      = 1'b0;
         ALUSrcA       = 1'b0;
         ALUSrcB       = 2'b00;
         OpALU         = 2'b00;
         PCSource      = 2'b00;
         illegal_op    = 1'b0;
         state         = 4'd0;
         instr_retired = '0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench: an instruction-level model expands each
// opcode into its step list and expected per-cycle control values.
module tb_mips_multicycle_control;
   import mips_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [5:0]    opcode = 6'd0;
   logic          mem_ready = 1'b0;
   logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic          MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0]    ALUSrcB, OpALU, PCSource;
   logic [3:0]    state;
   logic [CW-1:0] instr_retired;

   int total = 0;
   int bad = 0;
   int modelRetired = 0;

   mips_multicycle_control #(.CNT_W(CW), .ENABLE_ADDI(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .PCWrite       (PCWrite),
      .PCWriteCond   (PCWriteCond),
      .IorD          (IorD),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .IRWrite       (IRWrite),
      .MemtoReg      (MemtoReg),
      .RegDst        (RegDst),
      .RegWrite      (RegWrite),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .OpALU         (OpALU),
      .PCSource      (PCSource),
      .illegal_op    (illegal_op),
      .state         (state),
      .instr_retired (instr_retired)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   logic [16:0] dutVec;
   assign dutVec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, OpALU, PCSource, illegal_op};

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Expected control word for one step of an instruction, written from the
   // per-step description of the control unit.
   function automatic logic [16:0] expOut(input logic [3:0] s, input logic mr);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
      logic [1:0] srcb, opalu, pcsrc;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = '0;
      srcb = 2'b00; opalu = 2'b00; pcsrc = 2'b00;
      case (s)
         S_FETCH:     begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
         S_DECODE:    srcb = 2'b11;
         S_MEM_ADDR:  begin srca = 1; srcb = 2'b10; end
         S_MEM_READ:  begin mrd = 1; iord = 1; end
         S_MEM_WB:    begin rw = 1; m2r = 1; end
         S_MEM_WRITE: begin mwr = 1; iord = 1; end
         S_EXECUTE:   begin srca = 1; opalu = 2'b10; end
         S_R_WB:      begin rw = 1; rdst = 1; end
         S_BRANCH:    begin srca = 1; opalu = 2'b01; pcwc = 1; pcsrc = 2'b01; end
         S_JUMP:      begin pcw = 1; pcsrc = 2'b10; end
         S_ADDI_EXEC: begin srca = 1; srcb = 2'b10; end
         S_ADDI_WB:   rw = 1;
         S_TRAP:      ill = 1;
         default:     ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, opalu, pcsrc, ill};
   endfunction

   task automatic applyReset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         reset = 1'b1;
         mem_ready = 1'b1;
         opcode = 6'($urandom);
         #2;
         checkOutput("rst_ctrl", 32'(dutVec), 32'd0);
         checkOutput("rst_state", 32'(state), 32'd0);
         checkOutput("rst_retired", 32'(instr_retired), 32'd0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      modelRetired = 0;
   endtask

   // Runs one instruction through the model and DUT. fetchWaits/memWaits force
   // that many leading not-ready cycles; waitPct adds random extra waits.
   task automatic applyStimulus(input logic [5:0] op, input int fetchWaits, input int memWaits,
                                input int waitPct);
      logic [3:0] steps[$];
      logic       legal;
      int         fw, mw, streak;
      logic       mr, waitable;
      fw = fetchWaits;
      mw = memWaits;
      legal = 1'b1;
      steps = {};
      steps.push_back(S_FETCH);
      steps.push_back(S_DECODE);
      case (op)
         6'b100011: begin steps.push_back(S_MEM_ADDR); steps.push_back(S_MEM_READ); steps.push_back(S_MEM_WB); end
         6'b101011: begin steps.push_back(S_MEM_ADDR); steps.push_back(S_MEM_WRITE); end
         6'b000000: begin steps.push_back(S_EXECUTE); steps.push_back(S_R_WB); end
         6'b000100: steps.push_back(S_BRANCH);
         6'b000010: steps.push_back(S_JUMP);
         6'b001000: begin steps.push_back(S_ADDI_EXEC); steps.push_back(S_ADDI_WB); end
         default: begin
            legal = 1'b0;
            for (int i = 0; i < 20; i++) steps.push_back(S_TRAP);
         end
      endcase
      foreach (steps[k]) begin
         waitable = (steps[k] == S_FETCH) || (steps[k] == S_MEM_READ) || (steps[k] == S_MEM_WRITE);
         streak = 0;
         forever begin
            @(negedge clk);
            if (!waitable) mr = 1'($urandom);
            else if (steps[k] == S_FETCH && fw > 0) begin mr = 1'b0; fw--; end
            else if (steps[k] != S_FETCH && mw > 0) begin mr = 1'b0; mw--; end
            else if (streak < 4 && $urandom_range(0, 99) < waitPct) mr = 1'b0;
            else mr = 1'b1;
            if (!mr) streak++;
            mem_ready = mr;
            opcode = (steps[k] == S_FETCH) ? 6'($urandom) : op;
            #2;
            checkOutput("state", 32'(state), 32'(steps[k]));
            checkOutput("ctrl", 32'(dutVec), 32'(expOut(steps[k], mr)));
            checkOutput("retired", 32'(instr_retired), 32'(modelRetired % (1 << CW)));
            checkOutput("rw_excl", 32'(MemRead & MemWrite), 32'd0);
            if (!waitable || mr) break;
         end
      end
      if (legal) modelRetired++;
   endtask

   logic [5:0] legalOps[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

   initial begin
      applyReset();
      applyStimulus(6'b100011, 0, 0, 0);
      applyStimulus(6'b000000, 3, 0, 0);
      applyStimulus(6'b000100, 0, 0, 0);
      applyStimulus(6'b000010, 0, 0, 0);
      applyStimulus(6'b101011, 0, 3, 0);
      applyStimulus(6'b001000, 0, 0, 0);
      applyStimulus(6'b100011, 2, 2, 0);

      applyReset();
      for (int i = 0; i < 17; i++) applyStimulus(6'b000000, 0, 0, 0);
      @(negedge clk);
      #2 checkOutput("wrap_retired", 32'(instr_retired), 32'd1);

      applyReset();
      for (int i = 0; i < 80; i++)
         applyStimulus(legalOps[$urandom_range(0, 5)], 0, 0, 30);

      applyStimulus(6'b111111, 0, 0, 0);
      applyReset();
      applyStimulus(6'b000010, 0, 0, 0);
      applyStimulus(6'($urandom_range(48, 63)), 0, 0, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
